// File: rtl/audio_i2s_tx_if.sv
// rtl/audio_i2s_tx_if.sv - sample input, flag clear and I2S output bundle for audio_i2s_tx
interface audio_i2s_tx_if;
    logic        sample_valid;
    logic [12:0] sample_in;
    logic        clr_flags;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underrun;
    logic        overrun;

    modport master (
        output sample_valid, sample_in, clr_flags,
        input  i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun
    );

    modport slave (
        input  sample_valid, sample_in, clr_flags,
        output i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - mono 13-bit synth sample to 16-bit stereo I2S transmitter
module audio_i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int GAIN_SHIFT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    audio_i2s_tx_if.slave  bus
);

    localparam logic [7:0] DIV_MAX = 8'(BCLK_DIV - 1);

    logic [7:0]  div_cnt;
    logic        bclk_q;
    logic        lrclk_q;
    logic        sdata_q;
    logic [4:0]  bit_cnt;
    logic [31:0] shift_q;
    logic [15:0] pending_q;
    logic        pending_valid_q;
    logic [15:0] last_word_q;
    logic        underrun_q;
    logic        overrun_q;

    logic        div_wrap;
    logic        bclk_fall;
    logic        frame_load;
    logic [4:0]  bit_cnt_nxt;
    logic [15:0] load_word;
    logic [15:0] centred;
    logic [15:0] sample_word;
    logic        underrun_set;
    logic        overrun_set;

    always_comb begin
        div_wrap     = (div_cnt == DIV_MAX);
        bclk_fall    = div_wrap && bclk_q;
        frame_load   = bclk_fall && (bit_cnt == 5'd31);
        bit_cnt_nxt  = bit_cnt + 5'd1;
        load_word    = pending_valid_q ? pending_q : last_word_q;
        centred      = {3'b000, bus.sample_in} - 16'd4096;
        sample_word  = centred << GAIN_SHIFT;
        underrun_set = frame_load && !pending_valid_q;
        // A sample landing on the load cycle is not an overrun: the old word leaves as the new one arrives.
        overrun_set  = bus.sample_valid && pending_valid_q && !frame_load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt         <= 8'd0;
            bclk_q          <= 1'b0;
            lrclk_q         <= 1'b0;
            sdata_q         <= 1'b0;
            bit_cnt         <= 5'd0;
            shift_q         <= 32'd0;
            pending_q       <= 16'd0;
            pending_valid_q <= 1'b0;
            last_word_q     <= 16'd0;
            underrun_q      <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            div_cnt <= div_wrap ? 8'd0 : div_cnt + 8'd1;
            if (div_wrap) begin
                bclk_q <= ~bclk_q;
            end

            // The bit leaving at the load edge is the previous right-channel LSB, which gives the one-bit I2S delay.
            if (bclk_fall) begin
                bit_cnt <= bit_cnt_nxt;
                lrclk_q <= bit_cnt_nxt[4];
                sdata_q <= shift_q[31];
                if (frame_load) begin
                    shift_q     <= {load_word, load_word};
                    last_word_q <= load_word;
                end else begin
                    shift_q <= {shift_q[30:0], 1'b0};
                end
            end

            if (bus.sample_valid) begin
                pending_q       <= sample_word;
                pending_valid_q <= 1'b1;
            end else if (frame_load) begin
                pending_valid_q <= 1'b0;
            end

            if (underrun_set) begin
                underrun_q <= 1'b1;
            end else if (bus.clr_flags) begin
                underrun_q <= 1'b0;
            end

            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_flags) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.i2s_bclk  = bclk_q;
    assign bus.i2s_lrclk = lrclk_q;
    assign bus.i2s_sdata = sdata_q;
    assign bus.underrun  = underrun_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - bench for audio_i2s_tx with an I2S receiver and frame-level model
module tb_audio_i2s_tx;

    localparam int BDIV  = 4;
    localparam int GAIN  = 3;
    localparam int FRAME = 64 * BDIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_i2s_tx_if bus ();

    audio_i2s_tx #(.BCLK_DIV(BDIV), .GAIN_SHIFT(GAIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] m_pend;
    logic [15:0] m_last;
    bit          m_pv;
    bit          m_und;
    bit          m_ovr;
    logic [15:0] exp_q[$];
    logic [15:0] rx_q[$];
    logic [15:0] last_rx;

    // Receiver: samples on BCLK rise; an LRCLK change marks the LSB of the word just finished.
    logic        prev_bclk;
    logic        prev_lr;
    logic        rx_started;
    logic [15:0] rx_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bclk  <= 1'b0;
            prev_lr    <= 1'b0;
            rx_started <= 1'b0;
            rx_acc     <= 16'd0;
            rx_q.delete();
        end else begin
            if (bus.i2s_bclk && !prev_bclk) begin
                rx_acc <= {rx_acc[14:0], bus.i2s_sdata};
                if (bus.i2s_lrclk != prev_lr) begin
                    if (rx_started) rx_q.push_back({rx_acc[14:0], bus.i2s_sdata});
                    rx_started <= 1'b1;
                end
                prev_lr <= bus.i2s_lrclk;
            end
            prev_bclk <= bus.i2s_bclk;
        end
    end

    function automatic logic [15:0] conv(input logic [12:0] s);
        int v;
        v = (int'(s) - 4096) * (1 << GAIN);
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic step(input bit v, input logic [12:0] s, input bit c);
        bit          load;
        bit          und_set;
        bit          ovr_set;
        logic [15:0] w;
        logic [31:0] expw;
        bus.sample_valid = v;
        bus.sample_in    = s;
        bus.clr_flags    = c;
        @(posedge clk);
        cyc++;
        load    = (cyc % FRAME == 0);
        und_set = load && !m_pv;
        ovr_set = v && m_pv && !load;
        if (load) begin
            w = m_pv ? m_pend : m_last;
            exp_q.push_back(w);
            exp_q.push_back(w);
            m_last = w;
            m_pv   = 1'b0;
        end
        if (v) begin
            m_pend = conv(s);
            m_pv   = 1'b1;
        end
        m_und = und_set ? 1'b1 : (c ? 1'b0 : m_und);
        m_ovr = ovr_set ? 1'b1 : (c ? 1'b0 : m_ovr);
        @(negedge clk);
        #1;
        while (rx_q.size() > 0) begin
            last_rx = rx_q.pop_front();
            expw = (exp_q.size() > 0) ? {16'd0, exp_q.pop_front()} : 32'h0001_0000;
            check("word", {16'd0, last_rx}, expw);
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target - 1) step(1'b0, 13'd0, 1'b0);
        step(1'b0, 13'd0, 1'b0);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_underrun"}, {31'd0, bus.underrun}, {31'd0, m_und});
        check({tag, "_overrun"},  {31'd0, bus.overrun},  {31'd0, m_ovr});
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = 13'd0;
        bus.clr_flags    = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        check("rst_bclk",  {31'd0, bus.i2s_bclk},  32'd0);
        check("rst_lrclk", {31'd0, bus.i2s_lrclk}, 32'd0);
        check("rst_sdata", {31'd0, bus.i2s_sdata}, 32'd0);
        check("rst_flags", {30'd0, bus.underrun, bus.overrun}, 32'd0);
        cyc    = 0;
        m_pend = 16'd0;
        m_last = 16'd0;
        m_pv   = 1'b0;
        m_und  = 1'b0;
        m_ovr  = 1'b0;
        exp_q.delete();
        exp_q.push_back(16'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = 13'd0;
        bus.clr_flags    = 1'b0;
        last_rx          = 16'd0;

        // Reset release timing and the silent first frame, then one full-scale sample.
        do_reset(3);
        run_to(BDIV - 1);
        check("bclk_pre_rise", {31'd0, bus.i2s_bclk}, 32'd0);
        step(1'b0, 13'd0, 1'b0);
        check("bclk_rise", {31'd0, bus.i2s_bclk}, 32'd1);
        run_to(2 * BDIV - 1);
        check("bclk_pre_fall", {31'd0, bus.i2s_bclk}, 32'd1);
        step(1'b0, 13'd0, 1'b0);
        check("bclk_fall", {31'd0, bus.i2s_bclk}, 32'd0);
        check("lrclk_left", {31'd0, bus.i2s_lrclk}, 32'd0);
        run_to(FRAME / 2 - 1);
        check("lrclk_pre_right", {31'd0, bus.i2s_lrclk}, 32'd0);
        check("sdata_frame0", {31'd0, bus.i2s_sdata}, 32'd0);
        step(1'b0, 13'd0, 1'b0);
        check("lrclk_right", {31'd0, bus.i2s_lrclk}, 32'd1);
        run_to(200);
        step(1'b1, 13'h1FFF, 1'b0);
        run_to(FRAME + FRAME / 2 + 8);
        check("max_left", {16'd0, last_rx}, 32'h7FF8);
        run_to(2 * FRAME - 1);
        check("max_no_underrun", {31'd0, bus.underrun}, 32'd0);
        check_flags("max");
        run_to(2 * FRAME + 8);
        check("max_right", {16'd0, last_rx}, 32'h7FF8);

        // Mid-frame reset, most negative sample, then starvation for two frames.
        do_reset(2);
        run_to(BDIV);
        check("rerst_bclk_rise", {31'd0, bus.i2s_bclk}, 32'd1);
        run_to(100);
        step(1'b1, 13'h0000, 1'b0);
        run_to(4 * FRAME + 8);
        check("min_repeat", {16'd0, last_rx}, 32'h8000);
        check("min_underrun", {31'd0, bus.underrun}, 32'd1);
        check_flags("min");

        // Clear coincident with an underrun-setting load keeps the flag; a lone clear drops it.
        run_to(5 * FRAME - 1);
        step(1'b0, 13'd0, 1'b1);
        check("clr_vs_set", {31'd0, bus.underrun}, 32'd1);
        step(1'b0, 13'd0, 1'b1);
        check("clr_alone", {31'd0, bus.underrun}, 32'd0);
        check_flags("clr");

        // Two samples in one frame overrun; the second one is sent.
        do_reset(2);
        run_to(50);
        step(1'b1, 13'h1000, 1'b0);
        run_to(60);
        step(1'b1, 13'h0800, 1'b0);
        check("overrun_set", {31'd0, bus.overrun}, 32'd1);
        run_to(FRAME + FRAME / 2 + 8);
        check("overrun_word", {16'd0, last_rx}, 32'hC000);
        step(1'b0, 13'd0, 1'b1);
        check("overrun_clr", {31'd0, bus.overrun}, 32'd0);

        // Sample on the exact load cycle goes out in the following frame, no overrun.
        run_to(2 * FRAME - 1);
        step(1'b1, 13'h1FFF, 1'b0);
        check("coincide_no_overrun", {31'd0, bus.overrun}, 32'd0);
        run_to(3 * FRAME - 8);
        check("coincide_old_word", {16'd0, last_rx}, 32'hC000);
        run_to(3 * FRAME + FRAME / 2 + 8);
        check("coincide_new_word", {16'd0, last_rx}, 32'h7FF8);
        check_flags("coincide");

        // Random sample arrivals and clears against the frame-level model.
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 2, 13'($urandom), $urandom_range(0, 149) == 0);
            if (i % 200 == 199) check_flags("rand");
        end
        check("backlog", {31'd0, exp_q.size() <= 3}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCLK_DIV, default 4: clk cycles per BCLK half-period; legal range 2..255.
REQ-002 SHALL have parameter GAIN_SHIFT, default 3: left shift applied after centring; legal range 0..3.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe; new sample present (driven by the synth sample strobe).
REQ-006 SHALL have port sample_in  input  13  unsigned mixed synth sample, midpoint 4096.
REQ-007 SHALL have port clr_flags  input  1  one-cycle strobe; clears sticky flags.
REQ-008 SHALL have port i2s_bclk  output  1  bit clock.
REQ-009 SHALL have port i2s_lrclk  output  1  word select; 0 = left, 1 = right.
REQ-010 SHALL have port i2s_sdata  output  1  serial data, MSB first.
REQ-011 SHALL have port underrun  output  1  sticky; a frame started with no new sample.
REQ-012 SHALL have port overrun  output  1  sticky; a pending sample was overwritten.

Function
REQ-013 SHALL run a divider counting 0..BCLK_DIV-1 and toggle i2s_bclk on each wrap, giving a BCLK period of 2*BCLK_DIV clk cycles.
REQ-014 SHALL keep a 5-bit bit counter that advances (mod 32) on each BCLK falling edge only; a frame is 32 BCLK periods, 16 per channel.
REQ-015 SHALL update i2s_lrclk and i2s_sdata only on BCLK falling edges; i2s_lrclk equals bit counter bit 4 after the advance.
REQ-016 SHALL use standard I2S one-bit delay: the word MSB appears at bit counter values 1 (left) and 17 (right); the word LSB appears at bit counter values 16 (left) and 0 of the following frame (right).
REQ-017 SHALL convert each sample as word = (sample_in - 4096) << GAIN_SHIFT, in 16-bit two's complement with zero fill on the right. Examples: 0x1FFF -> 0x7FF8, 0x0000 -> 0x8000, 0x1000 -> 0x0000.
REQ-018 SHALL latch the converted word into a pending register and set pending_valid on sample_valid.
REQ-019 SHALL perform a frame load on the BCLK falling edge where the bit counter goes 31 -> 0. At that load:
- the pending word goes into the shift register for both left and right (mono duplicate);
- last_word is updated to the pending word;
- pending_valid is cleared.
REQ-020 SHALL, at a frame load with pending_valid=0, reload last_word for both channels and set underrun.
REQ-021 SHALL set overrun when sample_valid arrives while pending_valid=1 with no frame load in the same cycle; the new sample replaces the pending one.
REQ-022 SHALL, when sample_valid coincides with a frame load, load the old pending or last word into the frame, store the new sample as pending with pending_valid=1, and not set overrun.
REQ-023 SHALL give set priority over clr_flags when a flag-setting event and clr_flags occur in the same cycle.
REQ-024 SHALL ignore sample_in when sample_valid=0.

Reset
REQ-025 SHALL, while rst_n=0, clear i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun, the divider, the bit counter, pending_valid and the shift register.
REQ-026 SHALL reset last_word to 0x0000 (silence) at reset.
REQ-027 SHALL start the first BCLK rise BCLK_DIV cycles after rst_n rises and the first fall 2*BCLK_DIV cycles after it.
REQ-028 SHALL discard any frame in progress when reset is asserted mid-frame; output restarts from the REQ-027 state.

Verification
REQ-029 Reset release, BCLK_DIV=4 -> bclk rises at cycle 4 and falls at cycle 8; lrclk=0; sdata=0 through the first frame; frame length is 256 clk.
REQ-030 One sample 0x1FFF before the first frame load -> next frame serializes 0x7FF8 on left (MSB at bit 1) and on right (MSB at bit 17); no flags set.
REQ-031 Samples 0x0000 then no further samples for 2 frames -> first frame 0x8000/0x8000, next two frames repeat 0x8000, underrun=1, overrun=0.
REQ-032 Samples 0x1000 then 0x0800 within one frame -> overrun=1; next frame carries 0xC000 (from 0x0800).
REQ-033 sample_valid on the exact frame-load cycle -> that sample is serialized in the following frame; overrun stays 0.
REQ-034 clr_flags coincident with an underrun event -> underrun stays 1; clr_flags alone one cycle later -> 0.
